// File: rtl/aes_pkg.sv
// aes_pkg: shared types, schedule geometry and byte/word helpers for the AES
// key schedule.
//   - Schedule geometry (NK/NR/NW) for each supported key size.
//   - xtime(): GF(2^8) multiply-by-x used to step the round constant.
//   - rot_word(): cyclic left byte rotation of a schedule word.
//   - State encoding and word/round-key typedefs.
package aes_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RK_W   = 128;
  localparam int unsigned WIDX_W = 6;
  localparam int unsigned RIDX_W = 4;

  localparam int unsigned NK_128 = 4;
  localparam int unsigned NR_128 = 10;
  localparam int unsigned NW_128 = 44;
  localparam int unsigned NK_192 = 6;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NW_192 = 52;
  localparam int unsigned NK_256 = 8;
  localparam int unsigned NR_256 = 14;
  localparam int unsigned NW_256 = 60;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RK_W-1:0]   rk_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // {b0,b1,b2,b3} -> {b1,b2,b3,b0}, b0 being the most significant byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
//   in_i  [7:0]  input byte
//   out_o [7:0]  substituted byte
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational SubWord, one S-box per byte of a 32-bit word.
//   word_i [31:0]  input word
//   word_o [31:0]  byte-wise substituted word
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    aes_sbox u_sbox (
      .in_i  (word_i[8*b +: 8]),
      .out_o (word_o[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/192/256 key expansion, one schedule word
// per clock, with a registered round-key read port for the round engine.
//   clk, rst_n  clock, synchronous active-low reset
//   start       one-cycle request to expand key_in (ignored while busy)
//   key_in      cipher key, word 0 in the most significant 32 bits
//   rk_idx      round key index 0..NR; larger indices read as zero
//   busy        expansion in progress
//   done        one-cycle pulse on completion
//   key_ready   all round keys valid until the next start or reset
//   rk_out      round key rk_idx, one cycle after the index is presented
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic [RIDX_W-1:0]   rk_idx,
  output logic                busy,
  output logic                done,
  output logic                key_ready,
  output logic [RK_W-1:0]     rk_out
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  state_e              state_q;
  logic [WIDX_W-1:0]   i_q;
  logic [2:0]          j_q;
  logic [7:0]          rcon_q;
  logic                busy_q;
  logic                done_q;
  logic                key_ready_q;
  rk_t                 rk_q;
  word_t               w_q [NW];

  word_t               prev_word_c;
  word_t               back_word_c;
  word_t               sub_in_c;
  word_t               sub_out_c;
  word_t               temp_c;
  word_t               word_d;
  logic                start_ok_c;
  logic [WIDX_W-1:0]   rk_base_c;

  assign start_ok_c = start && (state_q != ST_EXPAND);

  // Next schedule word; j_q tracks i%NK so no divider is needed.
  assign prev_word_c = w_q[i_q - WIDX_W'(1)];
  assign back_word_c = w_q[i_q - WIDX_W'(NK)];
  assign sub_in_c    = (j_q == 3'd0) ? rot_word(prev_word_c) : prev_word_c;

  aes_sub_word u_sub_word (
    .word_i (sub_in_c),
    .word_o (sub_out_c)
  );

  always_comb begin
    temp_c = prev_word_c;
    if (j_q == 3'd0) begin
      temp_c = sub_out_c ^ {rcon_q, 24'h0};
    end else if ((NK == 8) && (j_q == 3'd4)) begin
      temp_c = sub_out_c;
    end
    word_d = back_word_c ^ temp_c;
  end

  // Schedule storage: not reset, only trusted while key_ready is set.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (start_ok_c) begin
        for (int k = 0; k < int'(NK); k++) begin
          w_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
        end
      end else if (state_q == ST_EXPAND) begin
        w_q[i_q] <= word_d;
      end
    end
  end

  assign rk_base_c = {rk_idx, 2'b00};

  // Control FSM, counters, round constant and read register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_q        <= '0;
    end else begin
      done_q <= 1'b0;

      if (key_ready_q && (rk_idx <= RIDX_W'(NR))) begin
        rk_q <= {w_q[rk_base_c], w_q[rk_base_c | WIDX_W'(1)],
                 w_q[rk_base_c | WIDX_W'(2)], w_q[rk_base_c | WIDX_W'(3)]};
      end else begin
        rk_q <= '0;
      end

      case (state_q)
        ST_IDLE, ST_READY: begin
          if (start) begin
            i_q         <= WIDX_W'(NK);
            j_q         <= '0;
            rcon_q      <= 8'h01;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          i_q <= i_q + WIDX_W'(1);
          j_q <= (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
          if (j_q == 3'd0) begin
            rcon_q <= xtime(rcon_q);
          end
          if (i_q == WIDX_W'(NW - 1)) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            key_ready_q <= 1'b1;
            state_q     <= ST_READY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_ready = key_ready_q;
  assign rk_out    = rk_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Testbench for aes_key_expander: one instance per key size, scoreboarded reads
// and done-latency checks against FIPS-197 reference vectors.
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_r     [3];
  logic [3:0]    rk_idx_r    [3];
  logic          busy_w      [3];
  logic          done_w      [3];
  logic          key_ready_w [3];
  logic [127:0]  rk_out_w    [3];
  logic [127:0]  key128;
  logic [191:0]  key192;
  logic [255:0]  key256;

  aes_key_expander #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .key_in(key128), .rk_idx(rk_idx_r[0]),
    .busy(busy_w[0]), .done(done_w[0]), .key_ready(key_ready_w[0]), .rk_out(rk_out_w[0])
  );
  aes_key_expander #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .key_in(key192), .rk_idx(rk_idx_r[1]),
    .busy(busy_w[1]), .done(done_w[1]), .key_ready(key_ready_w[1]), .rk_out(rk_out_w[1])
  );
  aes_key_expander #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .key_in(key256), .rk_idx(rk_idx_r[2]),
    .busy(busy_w[2]), .done(done_w[2]), .key_ready(key_ready_w[2]), .rk_out(rk_out_w[2])
  );

  // FIPS-197 A.1 round keys for key 2b7e151628aed2a6abf7158809cf4f3c.
  logic [127:0] gold128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct {
    int           dut;
    logic [127:0] exp;
    string        name;
  } rd_exp_t;

  typedef struct {
    int dut;
    int start_edge;
    int lat;
  } done_exp_t;

  rd_exp_t   rd_q   [$];
  done_exp_t done_q [$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  // Monitor: compare each read result and each done pulse against the queues.
  always @(negedge clk) begin : monitor
    rd_exp_t e;
    int      found;
    if (mon_en) begin
      if (rd_vld) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_underflow: read result with no expectation queued");
        end else begin
          e = rd_q.pop_front();
          if (rk_out_w[e.dut] !== e.exp) begin
            errors++;
            $display("FAIL %s: rk_out=%032h expected=%032h", e.name, rk_out_w[e.dut], e.exp);
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        if (done_w[d]) begin
          checks++;
          found = -1;
          for (int k = 0; k < done_q.size(); k++) begin
            if (found < 0 && done_q[k].dut == d) found = k;
          end
          if (found < 0) begin
            errors++;
            $display("FAIL done_unexpected: dut%0d done pulse at cycle %0d, expected none", d, cyc);
          end else begin
            if (cyc - done_q[found].start_edge != done_q[found].lat) begin
              errors++;
              $display("FAIL done_latency: dut%0d latency=%0d expected=%0d", d,
                       cyc - done_q[found].start_edge, done_q[found].lat);
            end
            done_q.delete(found);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // lat < 0: no done pulse expected from this start.
  task automatic do_start(input int d, input int lat);
    done_exp_t de;
    start_r[d] = 1'b1;
    if (lat >= 0) begin
      de.dut = d; de.start_edge = cyc + 1; de.lat = lat;
      done_q.push_back(de);
    end
    @(negedge clk);
    start_r[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [3:0] idx, input logic [127:0] exp, input string nm);
    rd_exp_t e;
    e.dut = d; e.exp = exp; e.name = nm;
    rk_idx_r[d] = idx;
    rd_req = 1'b1;
    rd_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_ready(input int d, input int budget, input string nm);
    int n = 0;
    while (!key_ready_w[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!key_ready_w[d]) begin
      errors++;
      $display("FAIL %s: key_ready=0 after %0d cycles, expected 1", nm, budget);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_r[d]  = 1'b0;
      rk_idx_r[d] = 4'd0;
    end
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset state of every instance
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_busy%0d", d),      128'(busy_w[d]),      128'h0);
      check($sformatf("reset_done%0d", d),      128'(done_w[d]),      128'h0);
      check($sformatf("reset_keyready%0d", d),  128'(key_ready_w[d]), 128'h0);
      check($sformatf("reset_rkout%0d", d),     rk_out_w[d],          128'h0);
    end

    // 1: AES-128 FIPS vector; reads while expanding return zero
    do_start(0, 40);
    check("t1_busy", 128'(busy_w[0]), 128'h1);
    do_read(0, 4'd1, 128'h0, "t1_read_during_expand");
    wait_ready(0, 60, "t1_ready");
    do_read(0, 4'd1,  gold128[1],  "t1_rk1");
    do_read(0, 4'd10, gold128[10], "t1_rk10");

    // 2: AES-192
    do_start(1, 46);
    wait_ready(1, 80, "t2_ready");
    do_read(1, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, "t2_rk12");
    do_read(1, 4'd13, 128'h0, "t2_rk13_out_of_range");
    do_read(1, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, "t2_rk0");

    // 3: AES-256
    do_start(2, 52);
    wait_ready(2, 80, "t3_ready");
    do_read(2, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "t3_rk14");
    do_read(2, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, "t3_rk0");
    do_read(2, 4'd15, 128'h0, "t3_rk15_out_of_range");

    // 4: start during expansion is ignored, then restart from READY
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    do_start(0, 40);
    repeat (9) @(negedge clk);
    key128 = 128'h000102030405060708090a0b0c0d0e0f;
    do_start(0, -1);
    check("t4_busy_after_ignored_start", 128'(busy_w[0]), 128'h1);
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    wait_ready(0, 60, "t4_ready");
    do_read(0, 4'd1,  gold128[1],  "t4_rk1");
    do_read(0, 4'd10, gold128[10], "t4_rk10");
    key128 = 128'h000102030405060708090a0b0c0d0e0f;
    do_start(0, 40);
    wait_ready(0, 60, "t4_ready2");
    do_read(0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "t4_rk10_key2");
    do_read(0, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, "t4_rk0_key2");

    // 5: reset mid-expansion aborts without a done pulse
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    do_start(0, -1);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy",     128'(busy_w[0]),      128'h0);
    check("t5_keyready", 128'(key_ready_w[0]), 128'h0);
    check("t5_rkout",    rk_out_w[0],          128'h0);
    repeat (30) @(negedge clk);
    check("t5_keyready_stays_low", 128'(key_ready_w[0]), 128'h0);
    do_start(0, 40);
    wait_ready(0, 60, "t5_ready");

    // 6: back-to-back index sweep including out-of-range indices
    for (int k = 0; k < 16; k++) begin
      do_read(0, 4'(k), (k <= 10) ? gold128[k] : 128'h0, $sformatf("t6_sweep_rk%0d", k));
    end

    repeat (3) @(negedge clk);
    check("end_pending_reads", 128'(rd_q.size()),   128'h0);
    check("end_pending_dones", 128'(done_q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
